muldiv_seq: RTL and testbench
=============================

# muldiv_seq

Sequencer for the multi-cycle multiply/divide unit in the Execute stage. Accepts a MULT/MULTU/DIV/DIVU operation from E, drives the external iterative divider through its start/ready/annul handshake (or runs an internal multi-cycle multiply), and holds the pipeline with a stall while busy. It then issues a single HI/LO write with the 64-bit result. Sits beside the ALU and feeds the hazard unit (stall) and the HI/LO register (write port).

## Interface
- MUL_CYCLES, 2, stall cycles spent in MUL_BUSY for a multiply; legal range 1..15.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- op_valid  in  1  E-stage instruction is a mult/div class op.
- op_sel  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- src_a, src_b  in  32  forwarded E-stage operands (rs, rt).
- flush  in  1  kill the in-flight op (exception or E flush).
- ext_stall  in  1  E held by another hazard source.
- div_start  out  1  one-cycle start pulse to the divider.
- div_signed  out  1  signed divide select.
- div_opa, div_opb  out  32  latched dividend and divisor.
- div_annul  out  1  one-cycle abort pulse to the divider.
- div_ready  in  1  divider result valid.
- div_result  in  64  divider result: {remainder, quotient}.
- stall_o  out  1  stall F/D/E while the op is unfinished.
- hilo_we  out  1  HI/LO write enable, one-cycle pulse.
- hi_wdata, lo_wdata  out  32  HI/LO write data.

## Operation
- States: IDLE, MUL_BUSY, DIV_BUSY, DONE.
- IDLE, op_valid & ~flush:
  - Latch src_a/src_b and op_sel.
  - MULT/MULTU: go to MUL_BUSY and load counter = MUL_CYCLES-1.
  - DIV/DIVU with src_b != 0: pulse div_start, go to DIV_BUSY.
  - DIV/DIVU with src_b == 0: do not start the divider; go to DONE with hi = src_a, lo = 32'hFFFF_FFFF.
- MUL_BUSY:
  - Decrement the counter each cycle.
  - At 0, capture the product of the latched operands and go to DONE.
  - MULT: signed 32x32 -> 64. MULTU: unsigned 32x32 -> 64.
  - hi = product[63:32], lo = product[31:0].
- DIV_BUSY:
  - Wait for div_ready, then capture hi = div_result[63:32], lo = div_result[31:0] and go to DONE.
  - div_ready seen in any other state is ignored.
- DONE:
  - hilo_we is high only on the first cycle in DONE.
  - Leave to IDLE when ext_stall = 0. While ext_stall = 1, stay in DONE with no repeat write and no restart.
- flush in MUL_BUSY or DIV_BUSY: go to IDLE with no write. If in DIV_BUSY, also pulse div_annul.
- flush on the first DONE cycle: gate hilo_we off, go to IDLE.
- flush in IDLE has priority over op_valid.
- stall_o = (IDLE & op_valid & ~flush) | MUL_BUSY | DIV_BUSY. It is 0 in DONE.
- div_signed = latched op_sel == DIV.
- div_opa and div_opb come from registers and are stable for the whole of DIV_BUSY.

## Timing
- Reset:
  - State IDLE; counter 0.
  - hi/lo registers, div_opa, div_opb and div_signed are 0.
  - stall_o, hilo_we, div_start and div_annul are 0 while rst is high.
- Multiply latency: op_valid seen in IDLE at cycle 0; stall_o high for cycles 0..MUL_CYCLES; hilo_we at cycle MUL_CYCLES+1.
- Divide latency: div_start at cycle 0; if div_ready arrives at cycle N, hilo_we is at N+1 and stall_o is high for 0..N.
- Divide by zero: stall_o high at cycle 0 only; hilo_we at cycle 1.
- Pulse outputs (div_start, div_annul, hilo_we) are registered and last exactly one cycle.
- Reset asserted mid-operation: immediate return to IDLE and no write. The divider is reset by the same rst.

## Structure
- muldiv_pkg holds:
  - state enum (IDLE, MUL_BUSY, DIV_BUSY, DONE);
  - op_sel constants OP_MULT, OP_MULTU, OP_DIV, OP_DIVU;
  - DIV0_LO = 32'hFFFF_FFFF.
- No sub-module: the multiply, counter and FSM are all internal.
- The divider stays external and connects through the div_* ports.

## Test plan
- MULT with src_a = -3, src_b = 7, MUL_CYCLES = 2 -> stall_o high 3 cycles; hilo_we on cycle 3 with hi = FFFF_FFFF, lo = FFFF_FFEB.
- DIVU with 100 / 7, div_ready 32 cycles after start -> one div_start; lo = 14, hi = 2; stall_o drops the same cycle hilo_we rises.
- DIV with src_b = 0, src_a = 5 -> no div_start; next cycle hilo_we with hi = 5, lo = FFFF_FFFF.
- DIV in flight, flush 10 cycles after start -> div_annul for one cycle, return to IDLE, no hilo_we; a later stray div_ready is ignored.
- MULTU with 0xFFFF_FFFF squared, ext_stall held 3 cycles in DONE -> single hilo_we (hi = FFFF_FFFE, lo = 0000_0001), no restart while op_valid stays high.
- Reset asserted during DIV_BUSY -> all outputs 0 immediately; a new DIV accepted after release.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the multiply/divide sequencer.
package muldiv_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_BUSY = 2'd1,
        DIV_BUSY = 2'd2,
        DONE     = 2'd3
    } state_e;

    localparam logic [1:0]  OP_MULT  = 2'b00;
    localparam logic [1:0]  OP_MULTU = 2'b01;
    localparam logic [1:0]  OP_DIV   = 2'b10;
    localparam logic [1:0]  OP_DIVU  = 2'b11;

    localparam logic [31:0] DIV0_LO  = 32'hFFFF_FFFF;

endpackage

// File: rtl/muldiv_seq.sv
// Execute-stage mult/div sequencer: internal multi-cycle multiply, external divider handshake, single HI/LO write.
// Multiply writes MUL_CYCLES+1 cycles after accept; stall_o holds the pipeline while busy, ext_stall parks DONE.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic [1:0]  op_sel,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    input  logic        ext_stall,
    output logic        div_start,
    output logic        div_signed,
    output logic [31:0] div_opa,
    output logic [31:0] div_opb,
    output logic        div_annul,
    input  logic        div_ready,
    input  logic [63:0] div_result,
    output logic        stall_o,
    output logic        hilo_we,
    output logic [31:0] hi_wdata,
    output logic [31:0] lo_wdata
);

    localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] opa_q, opa_d;
    logic [31:0] opb_q, opb_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        start_q, start_d;
    logic        annul_q, annul_d;
    logic        we_q, we_d;

    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic        [63:0] prod;

    assign prod_s = 64'($signed(opa_q)) * 64'($signed(opb_q));
    assign prod_u = 64'(opa_q) * 64'(opb_q);
    assign prod   = (op_q == OP_MULT) ? prod_s : prod_u;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        start_d = 1'b0;
        annul_d = 1'b0;
        we_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (op_valid && !flush) begin
                    op_d  = op_sel;
                    opa_d = src_a;
                    opb_d = src_b;
                    if (op_sel == OP_MULT || op_sel == OP_MULTU) begin
                        state_d = MUL_BUSY;
                        cnt_d   = MUL_LOAD;
                    end else if (src_b != 32'd0) begin
                        state_d = DIV_BUSY;
                        start_d = 1'b1;
                    end else begin
                        // Divide by zero never reaches the divider.
                        state_d = DONE;
                        hi_d    = src_a;
                        lo_d    = DIV0_LO;
                        we_d    = 1'b1;
                    end
                end
            end
            MUL_BUSY: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (cnt_q == 4'd0) begin
                    state_d = DONE;
                    hi_d    = prod[63:32];
                    lo_d    = prod[31:0];
                    we_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DIV_BUSY: begin
                if (flush) begin
                    state_d = IDLE;
                    annul_d = 1'b1;
                end else if (div_ready) begin
                    state_d = DONE;
                    hi_d    = div_result[63:32];
                    lo_d    = div_result[31:0];
                    we_d    = 1'b1;
                end
            end
            DONE: begin
                if (flush || !ext_stall) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            op_q    <= 2'b00;
            opa_q   <= 32'd0;
            opb_q   <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            start_q <= 1'b0;
            annul_q <= 1'b0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            start_q <= start_d;
            annul_q <= annul_d;
            we_q    <= we_d;
        end
    end

    // rst gates the combinational accept term so stall_o is 0 throughout reset.
    assign stall_o    = !rst && ((state_q == IDLE && op_valid && !flush) ||
                                 state_q == MUL_BUSY || state_q == DIV_BUSY);
    assign hilo_we    = we_q && !flush;
    assign hi_wdata   = hi_q;
    assign lo_wdata   = lo_q;
    assign div_start  = start_q;
    assign div_annul  = annul_q;
    assign div_signed = (op_q == OP_DIV);
    assign div_opa    = opa_q;
    assign div_opb    = opb_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboarded bench for muldiv_seq: directed ops push expected HI/LO, a negedge monitor pops on each write.
module tb_muldiv_seq;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        op_valid = 1'b0;
    logic [1:0]  op_sel = 2'b00;
    logic [31:0] src_a = 32'd0;
    logic [31:0] src_b = 32'd0;
    logic        flush = 1'b0;
    logic        ext_stall = 1'b0;
    logic        div_ready = 1'b0;
    logic [63:0] div_result = 64'd0;
    logic        div_start, div_signed, div_annul, stall_o, hilo_we;
    logic [31:0] div_opa, div_opb, hi_wdata, lo_wdata;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    int start_cnt = 0;
    logic [63:0] exp_q[$];

    muldiv_seq #(.MUL_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_sel(op_sel),
        .src_a(src_a), .src_b(src_b), .flush(flush), .ext_stall(ext_stall),
        .div_start(div_start), .div_signed(div_signed), .div_opa(div_opa),
        .div_opb(div_opb), .div_annul(div_annul), .div_ready(div_ready),
        .div_result(div_result), .stall_o(stall_o), .hilo_we(hilo_we),
        .hi_wdata(hi_wdata), .lo_wdata(lo_wdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (!rst && div_start) start_cnt++;
        if (!rst && hilo_we) begin
            wr_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got %h%h expected no write", hi_wdata, lo_wdata);
            end else begin
                chk("hilo_data", {hi_wdata, lo_wdata}, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, s0;

        // Reset state
        samp();
        chk("rst_stall", stall_o, 0);
        chk("rst_we", hilo_we, 0);
        chk("rst_start", div_start, 0);
        chk("rst_annul", div_annul, 0);
        chk("rst_opa_opb", {div_opa, div_opb}, 0);
        chk("rst_data", {hi_wdata, lo_wdata}, 0);
        step(); step();
        rst = 1'b0;
        step();

        // MULT -3 * 7
        op_valid = 1; op_sel = OP_MULT; src_a = -32'sd3; src_b = 32'd7;
        exp_q.push_back(64'hFFFF_FFFF_FFFF_FFEB);
        samp(); chk("mul_stall_c0", stall_o, 1);
        step(); op_valid = 0;
        samp(); chk("mul_stall_c1", stall_o, 1);
        step();
        samp(); chk("mul_stall_c2", stall_o, 1); chk("mul_we_c2", hilo_we, 0);
        step();
        samp(); chk("mul_stall_c3", stall_o, 0); chk("mul_we_c3", hilo_we, 1);
        step();
        samp(); chk("mul_we_c4", hilo_we, 0);
        step();

        // DIVU 100 / 7, ready 32 cycles after start
        s0 = start_cnt;
        op_valid = 1; op_sel = OP_DIVU; src_a = 32'd100; src_b = 32'd7;
        exp_q.push_back({32'd2, 32'd14});
        samp(); chk("divu_stall_acc", stall_o, 1); chk("divu_nostart_acc", div_start, 0);
        step(); op_valid = 0; src_a = 32'hDEAD_BEEF; src_b = 32'h1234_5678;
        samp(); chk("divu_start", div_start, 1); chk("divu_ops", {div_opa, div_opb}, {32'd100, 32'd7});
        chk("divu_unsigned", div_signed, 0);
        for (int i = 1; i < 32; i++) begin
            step();
            samp();
            if (stall_o !== 1'b1 || div_start !== 1'b0 || div_opa !== 32'd100) begin
                chk("divu_busy_hold", {stall_o, div_start, div_opa}, {1'b1, 1'b0, 32'd100});
            end
        end
        step(); div_ready = 1; div_result = {32'd2, 32'd14};
        samp(); chk("divu_stall_N", stall_o, 1);
        step(); div_ready = 0; div_result = 64'd0;
        samp(); chk("divu_stall_N1", stall_o, 0); chk("divu_we_N1", hilo_we, 1);
        step();
        chk("divu_one_start", start_cnt - s0, 1);

        // DIV by zero
        s0 = start_cnt;
        op_valid = 1; op_sel = OP_DIV; src_a = 32'd5; src_b = 32'd0;
        exp_q.push_back({32'd5, 32'hFFFF_FFFF});
        samp(); chk("div0_stall_c0", stall_o, 1);
        step(); op_valid = 0;
        samp(); chk("div0_stall_c1", stall_o, 0); chk("div0_we_c1", hilo_we, 1);
        chk("div0_nostart", div_start, 0);
        step();
        chk("div0_start_cnt", start_cnt - s0, 0);

        // DIV flushed 10 cycles after start
        w0 = wr_cnt;
        op_valid = 1; op_sel = OP_DIV; src_a = -32'sd20; src_b = 32'd3;
        step(); op_valid = 0;
        samp(); chk("dflush_start", div_start, 1); chk("dflush_signed", div_signed, 1);
        for (int i = 1; i < 10; i++) step();
        step(); flush = 1;
        samp(); chk("dflush_annul_c10", div_annul, 0);
        step(); flush = 0;
        samp(); chk("dflush_annul", div_annul, 1); chk("dflush_stall", stall_o, 0);
        step();
        samp(); chk("dflush_annul_off", div_annul, 0);
        step(); div_ready = 1; div_result = 64'h1111_2222_3333_4444;
        samp(); chk("stray_stall", stall_o, 0);
        step(); div_ready = 0;
        samp(); chk("stray_we", hilo_we, 0);
        step(); step();
        chk("dflush_no_write", wr_cnt - w0, 0);

        // MULTU 0xFFFFFFFF^2, op_valid held, ext_stall held 3 cycles in DONE
        w0 = wr_cnt; s0 = start_cnt;
        op_valid = 1; op_sel = OP_MULTU; src_a = 32'hFFFF_FFFF; src_b = 32'hFFFF_FFFF;
        exp_q.push_back(64'hFFFF_FFFE_0000_0001);
        step(); step(); step(); ext_stall = 1;
        samp(); chk("mulu_we", hilo_we, 1); chk("mulu_stall_done", stall_o, 0);
        step();
        samp(); chk("mulu_hold1", {hilo_we, stall_o}, 0);
        step();
        samp(); chk("mulu_hold2", {hilo_we, stall_o}, 0);
        step(); ext_stall = 0; op_valid = 0;
        samp(); chk("mulu_hold3", {hilo_we, stall_o}, 0);
        step(); step();
        chk("mulu_one_write", wr_cnt - w0, 1);
        chk("mulu_no_start", start_cnt - s0, 0);

        // Reset during DIV_BUSY, then a new DIV
        w0 = wr_cnt;
        op_valid = 1; op_sel = OP_DIV; src_a = 32'd77; src_b = 32'd5;
        step(); op_valid = 0;
        step(); step();
        rst = 1; op_valid = 1;
        #1;
        chk("rstmid_outs", {stall_o, hilo_we, div_start, div_annul, div_signed}, 0);
        chk("rstmid_ops", {div_opa, div_opb}, 0);
        samp(); chk("rstmid_stall", stall_o, 0);
        step(); op_valid = 0;
        step(); rst = 0;
        step();
        chk("rstmid_no_write", wr_cnt - w0, 0);
        op_valid = 1; op_sel = OP_DIV; src_a = 32'd9; src_b = 32'd2;
        exp_q.push_back({32'd1, 32'd4});
        samp(); chk("post_rst_stall", stall_o, 1);
        step(); op_valid = 0;
        samp(); chk("post_rst_start", div_start, 1); chk("post_rst_ops", {div_opa, div_opb}, {32'd9, 32'd2});
        step(); div_ready = 1; div_result = {32'd1, 32'd4};
        step(); div_ready = 0;
        samp(); chk("post_rst_we", hilo_we, 1);
        step(); step();

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
